apb_clk_cfg_bridge: RTL

APB slave that converts processor register accesses into the req/ack configuration handshake of the clock-generator block. It serves three targets (soc, per, cluster), one transaction at a time, and returns read data from the selected target. It also exposes a lock-status register and aborts a handshake that exceeds a timeout. It sits between the SoC peripheral APB interconnect and the clock generator's cfg ports.

---
 rtl/apb_clk_cfg_bridge.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/apb_clk_cfg_bridge.sv
// ----------------------------------------------------------------------------
// apb_clk_cfg_bridge
//   APB slave that turns register accesses into the req/ack configuration
//   handshake of the clock generator. Three targets (soc, per, cluster) are
//   served one transaction at a time; a fourth address window returns the
//   per-target lock status. A handshake with no ack is aborted after
//   TIMEOUT_CYC cycles and reported as a slave error.
//
// Ports
//   ref_clk_i     clock (rising edge)
//   rstn_glob_i   asynchronous active-low reset
//   paddr_i       APB address, bits [5:4] select target, [3:2] register index
//   psel_i        APB select
//   penable_i     APB enable
//   pwrite_i      APB write strobe
//   pwdata_i      APB write data
//   prdata_o      APB read data (registered)
//   pready_o      APB ready (registered, one-cycle pulse)
//   pslverr_o     APB error (registered)
//   cfg_req_o     per-target request, bit0=soc bit1=per bit2=cluster
//   cfg_add_o     register index shared by all targets
//   cfg_data_o    write data shared by all targets
//   cfg_wrn_o     1 = write, 0 = read
//   cfg_ack_i     per-target acknowledge
//   cfg_r_data_i  per-target read data, 32 bits per target
//   cfg_lock_i    per-target lock status (status only, never gates requests)
// ----------------------------------------------------------------------------
module apb_clk_cfg_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYC    = 16
) (
  input  logic                      ref_clk_i,
  input  logic                      rstn_glob_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [2:0]                cfg_req_o,
  output logic [1:0]                cfg_add_o,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_wrn_o,
  input  logic [2:0]                cfg_ack_i,
  input  logic [95:0]               cfg_r_data_i,
  input  logic [2:0]                cfg_lock_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] TGT_STATUS = 2'd3;
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  cfg_req_q, cfg_req_d;
  logic [1:0]  cfg_add_q, cfg_add_d;
  logic [31:0] cfg_data_q, cfg_data_d;
  logic        cfg_wrn_q, cfg_wrn_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  logic [1:0]  tgt;
  logic [1:0]  idx;
  logic        ack_sel;
  logic [31:0] rdata_sel;
  logic        unused_paddr;

  assign tgt = paddr_i[5:4];
  assign idx = paddr_i[3:2];
  assign unused_paddr = ^{paddr_i[APB_ADDR_WIDTH-1:6], paddr_i[1:0]};

  // The request vector is one-hot for the active target, so masking the ack
  // with it ignores acks from targets that were not asked.
  assign ack_sel = |(cfg_ack_i & cfg_req_q);

  always_comb begin
    case (tgt_q)
      2'd0:    rdata_sel = cfg_r_data_i[31:0];
      2'd1:    rdata_sel = cfg_r_data_i[63:32];
      default: rdata_sel = cfg_r_data_i[95:64];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    cfg_req_d  = cfg_req_q;
    cfg_add_d  = cfg_add_q;
    cfg_data_d = cfg_data_q;
    cfg_wrn_d  = cfg_wrn_q;
    prdata_d   = prdata_q;
    pslverr_d  = pslverr_q;
    pready_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (psel_i && penable_i && !pready_q) begin
          if (tgt != TGT_STATUS) begin
            tgt_d      = tgt;
            cfg_add_d  = idx;
            cfg_data_d = pwdata_i;
            cfg_wrn_d  = pwrite_i;
            cfg_req_d  = 3'b001 << tgt;
            cnt_d      = 8'd0;
            state_d    = ST_REQ;
          end else begin
            // Status window is read-only; writes complete with an error.
            prdata_d  = pwrite_i ? 32'd0 : {29'd0, cfg_lock_i};
            pslverr_d = pwrite_i;
            pready_d  = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // Ack is evaluated first so an ack in the final cycle still succeeds.
        if (ack_sel) begin
          prdata_d  = cfg_wrn_q ? 32'd0 : rdata_sel;
          pslverr_d = 1'b0;
          cfg_req_d = 3'b000;
          pready_d  = 1'b1;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          prdata_d  = 32'd0;
          pslverr_d = 1'b1;
          cfg_req_d = 3'b000;
          pready_d  = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        cfg_req_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      state_q    <= ST_IDLE;
      tgt_q      <= 2'd0;
      cnt_q      <= 8'd0;
      cfg_req_q  <= 3'd0;
      cfg_add_q  <= 2'd0;
      cfg_data_q <= 32'd0;
      cfg_wrn_q  <= 1'b0;
      prdata_q   <= 32'd0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      cfg_req_q  <= cfg_req_d;
      cfg_add_q  <= cfg_add_d;
      cfg_data_q <= cfg_data_d;
      cfg_wrn_q  <= cfg_wrn_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
    end
  end

  assign cfg_req_o  = cfg_req_q;
  assign cfg_add_o  = cfg_add_q;
  assign cfg_data_o = cfg_data_q;
  assign cfg_wrn_o  = cfg_wrn_q;
  assign prdata_o   = prdata_q;
  assign pready_o   = pready_q;
  assign pslverr_o  = pslverr_q;

endmodule
